// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with stop/parity error flags and a receive FIFO.
// Define UART_RX_PARITY_EN to add the parity_mode port and parity checking.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
`ifdef UART_RX_PARITY_EN
  input  logic [1:0]           parity_mode,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam logic [CW-1:0] HALF  = CW'(OVS/2 - 1);
  localparam logic [CW-1:0] LAST  = CW'(OVS - 1);
  localparam logic [2:0]    DLAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    SLAST = 3'(STOP_BITS - 1);
  localparam logic [AW:0]   FULLC = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state_q;
  logic                 rx_s1_q, rx_s;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 ferr_q, perr_q;
  logic                 par_act, par_bad;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        hold_q, head, entry;
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [AW:0]          count_q;
  logic                 overrun_q;
  logic                 push, pop, full, do_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s    <= rx_s1_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic [1:0] pmode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pmode_q <= 2'b00;
    else if (tick && state_q == S_START && cnt_q == HALF && !rx_s)
      pmode_q <= parity_mode;
  end

  assign par_act = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  assign par_bad = (pmode_q == 2'b01) ? (^data_q ^ rx_s)
                                      : ~(^data_q ^ rx_s);
`else
  assign par_act = 1'b0;
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            state_q <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == LAST) begin
            cnt_q  <= '0;
            data_q <= {rx_s, data_q[DATA_BITS-1:1]};
            if (idx_q == DLAST) begin
              idx_q   <= '0;
              state_q <= par_act ? S_PARITY : S_STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            perr_q  <= par_bad;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == LAST) begin
            cnt_q  <= '0;
            ferr_q <= ferr_q | ~rx_s;
            if (idx_q == SLAST) begin
              idx_q   <= '0;
              state_q <= (ferr_q | ~rx_s) ? S_BREAK : S_IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign push = tick && state_q == S_STOP && cnt_q == LAST
                && idx_q == SLAST;
  assign entry   = {perr_q, ferr_q | ~rx_s, data_q};
  assign full    = count_q == FULLC;
  assign pop     = rx_valid && rx_ready;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && full && !pop;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        hold_q <= mem_q[rptr_q];
      end
      unique case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // An empty FIFO keeps showing the last popped entry.
  assign head       = (count_q != '0) ? mem_q[rptr_q] : hold_q;
  assign rx_data    = head[DATA_BITS-1:0];
  assign frame_err  = head[EW-2];
  assign parity_err = head[EW-1];
  assign rx_valid   = count_q != '0;
  assign overrun    = overrun_q;
  assign busy       = state_q != S_IDLE;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: serial frame driver, scoreboard of expected
// FIFO entries, and table of frames plus hand sequences for corners.
module tb_uart_rx_cfg;
  localparam int OVS = 16;

  logic       clk = 0;
  logic       rst = 1;
  logic       tick = 0;
  logic       rx = 1;
  logic       rx_ready = 1;
  logic [1:0] parity_mode = 2'b00;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun, busy;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ocnt = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       p;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] data;
    logic [1:0] pmode;
    logic       pbit;
    logic       eperr;
  } vec_t;
  vec_t tbl[$];

  uart_rx_cfg dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .rx(rx),
`ifdef UART_RX_PARITY_EN
    .parity_mode(parity_mode),
`endif
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tick = ~tick;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Pop-side scoreboard: a pop happens at the next posedge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (rx_valid) vcnt++;
      if (overrun) ocnt++;
      if (rx_valid && rx_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", {22'd0, rx_data, frame_err, parity_err},
              32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("pop_entry", {22'd0, rx_data, frame_err, parity_err},
              {22'd0, e});
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!tick);
    end
    @(negedge clk);
  endtask

  task automatic send_head(input logic [7:0] d);
    hold(1'b0, OVS);
    for (int i = 0; i < 8; i++) hold(d[i], OVS);
  endtask

  task automatic send(input logic [7:0] d, input logic par,
                      input logic pbit);
    send_head(d);
    if (par) hold(pbit, OVS);
    hold(1'b1, OVS);
    hold(1'b1, OVS);
  endtask

  task automatic expect_e(input logic [7:0] d, input logic f,
                          input logic p);
    exp_t e;
    e.d = d;
    e.f = f;
    e.p = p;
    sb.push_back(e);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    chk(nm, sb.size(), 0);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
    @(negedge clk);
  endtask

  initial begin
    logic par;
    tbl.push_back('{8'h3C, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{8'h00, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{8'h5A, 2'b00, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
    tbl.push_back('{8'h07, 2'b01, 1'b0, 1'b1});
    tbl.push_back('{8'h07, 2'b10, 1'b0, 1'b0});
    tbl.push_back('{8'hF0, 2'b10, 1'b0, 1'b1});
    tbl.push_back('{8'h13, 2'b01, 1'b1, 1'b0});
    tbl.push_back('{8'h22, 2'b11, 1'b0, 1'b0});
`endif

    repeat (4) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_data", rx_data, 0);
    rst = 0;
    hold(1'b1, 2 * OVS);

    // Single clean frame; valid lasts one clk with ready held high.
    vcnt = 0;
    expect_e(8'hA5, 1'b0, 1'b0);
    send(8'hA5, 1'b0, 1'b0);
    drain("a5_drain");
    repeat (4) @(negedge clk);
    chk("a5_valid_width", vcnt, 1);

    // Short low glitch must be rejected.
    hold(1'b0, 4);
    hold(1'b1, 2 * OVS);
    chk("glitch_busy", busy, 0);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_nopush", sb.size(), 0);
    expect_e(8'h3C, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    drain("glitch_next");

    foreach (tbl[k]) begin
      parity_mode = tbl[k].pmode;
      par = (tbl[k].pmode == 2'b01) || (tbl[k].pmode == 2'b10);
`ifdef UART_RX_PARITY_EN
      expect_e(tbl[k].data, 1'b0, tbl[k].eperr);
`else
      expect_e(tbl[k].data, 1'b0, 1'b0);
`endif
      send(tbl[k].data, par, tbl[k].pbit);
      drain("table_drain");
    end
    parity_mode = 2'b00;

    // Stop bit held low for three bit times.
    expect_e(8'h55, 1'b1, 1'b0);
    send_head(8'h55);
    hold(1'b0, 2 * OVS);
    chk("break_busy", busy, 1);
    hold(1'b0, OVS);
    chk("break_busy_hold", busy, 1);
    hold(1'b1, OVS);
    chk("break_exit", busy, 0);
    drain("ferr_drain");
    expect_e(8'h12, 1'b0, 1'b0);
    send(8'h12, 1'b0, 1'b0);
    drain("after_break");

    // Fill the FIFO with the consumer stalled.
    set_ready(1'b0);
    ocnt = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) expect_e(8'(i), 1'b0, 1'b0);
      send(8'(i), 1'b0, 1'b0);
    end
    chk("full_valid", rx_valid, 1);
    chk("full_head", rx_data, 8'h01);
    chk("overrun_pulses", ocnt, 2);
    set_ready(1'b1);
    drain("full_drain");
    repeat (4) @(negedge clk);
    chk("empty_after_drain", rx_valid, 0);

    // Reset in the middle of data bit 3.
    hold(1'b0, OVS);
    hold(1'b1, 3 * OVS + OVS / 2);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_data", rx_data, 0);
    rst = 0;
    hold(1'b1, 6 * OVS);
    chk("midrst_nopush", rx_valid, 0);
    chk("midrst_idle", busy, 0);
    expect_e(8'h81, 1'b0, 1'b0);
    send(8'h81, 1'b0, 1'b0);
    drain("midrst_next");

    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set data bits per frame; legal range 5..8.
REQ-002 Parameter OVS, default 16, SHALL set tick pulses per bit; even, legal range 8..32.
REQ-003 Parameter STOP_BITS, default 1, SHALL set stop bits checked per frame; legal 1 or 2.
REQ-004 Parameter FIFO_DEPTH, default 4, SHALL set receive FIFO entries; power of 2, range 2..16.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 tick  input  1  oversample enable, one clk wide, OVS pulses per bit time.
REQ-008 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-009 parity_mode  input  2  00 none, 01 even, 10 odd, 11 none (present only with UART_RX_PARITY_EN).
REQ-010 rx_data  output  DATA_BITS  FIFO head data, LSB = first received bit.
REQ-011 rx_valid  output  1  FIFO non-empty; head entry valid.
REQ-012 rx_ready  input  1  consumer accepts head when high with rx_valid.
REQ-013 frame_err  output  1  head entry had a stop bit sampled low.
REQ-014 parity_err  output  1  head entry failed parity check.
REQ-015 overrun  output  1  one-clk pulse: completed frame dropped because FIFO full.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 rx SHALL pass a 2-flop synchroniser; all decisions use the synchronised value.
REQ-018 Sample counter and state SHALL advance only on clk edges where tick=1.
REQ-019 States SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-020 IDLE->START when synchronised rx=0 on a tick; counter cleared.
REQ-021 START SHALL resample at count OVS/2-1; rx=0 -> DATA with counter and bit index cleared; rx=1 -> IDLE (glitch rejected, nothing pushed).
REQ-022 DATA SHALL sample each bit at count OVS-1, LSB first; after bit DATA_BITS-1 go to PARITY when parity active, else STOP.
REQ-023 PARITY SHALL sample one bit at count OVS-1; error when even mode and XOR(data,bit)=1, or odd mode and XOR(data,bit)=0.
REQ-024 STOP SHALL sample each of STOP_BITS bits at count OVS-1; any low sample sets the frame error.
REQ-025 On the final stop sample the entry {parity_err, frame_err, data} SHALL be pushed; rx_valid rises on the following clk when FIFO was empty.
REQ-026 Push with FIFO full SHALL discard the new entry, keep FIFO contents, and pulse overrun for one clk.
REQ-027 Pop SHALL occur on any clk with rx_valid=1 and rx_ready=1; rx_data/flags then show next entry or hold when empty.
REQ-028 Simultaneous push and pop on a full FIFO SHALL succeed with no overrun; on an empty FIFO the entry appears as head next cycle.
REQ-029 After frame error, state SHALL go to BREAK, holding until synchronised rx=1 on a tick, then IDLE; no new start detected during BREAK.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-031 parity_mode SHALL be sampled at the START->DATA transition and held for the frame.

Reset
REQ-032 rst SHALL clear state to IDLE, counters, bit index, FIFO pointers and occupancy; synchroniser flops set to 1.
REQ-033 During reset rx_valid, overrun, frame_err, parity_err, busy SHALL be 0, rx_data all zeros.
REQ-034 rst asserted mid-frame SHALL abandon the frame with no push; after release a fresh start edge is required.

Configuration
REQ-035 Macro UART_RX_PARITY_EN defined: parity_mode port, PARITY state and checking present per REQ-023.
REQ-036 UART_RX_PARITY_EN undefined: no parity_mode port, PARITY state never entered, parity_err constant 0.

Verification
REQ-037 OVS=16, 8N1, byte 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid 1 clk, both errors 0.
REQ-038 rx low for 4 ticks then high -> no push, busy returns 0, next 0x3C frame received correctly.
REQ-039 Parity even, byte 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1; odd mode same frame -> parity_err=0.
REQ-040 Stop bit held low 3 bit times on 0x55 -> entry 0x55 frame_err=1, busy until rx high, next frame 0x12 clean.
REQ-041 FIFO_DEPTH=4, rx_ready=0, six frames 0x01..0x06 -> two overrun pulses, pops yield 0x01..0x04.
REQ-042 rst asserted at data bit 3 of 0xFF -> no entry, rx_valid=0; subsequent 0x81 received correctly.
